// File: rtl/hood_mode_scheduler_if.sv
// Button/tick inputs and mode outputs of the range-hood mode scheduler.
// The master side drives the pulses; the slave side is the scheduler.
interface hood_mode_scheduler_if #(
  parameter int TIMER_W = 8
);
  logic               tick_1hz;
  logic               power_btn;
  logic               menu_btn;
  logic               lvl1_btn;
  logic               lvl2_btn;
  logic               lvl3_btn;
  logic               clean_btn;
  logic [2:0]         state;
  logic [1:0]         speed;
  logic [TIMER_W-1:0] timer;
  logic               hurricane_used;
  logic               alert;
  logic               clean_done;

  modport master (
    output tick_1hz, power_btn, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn,
    input  state, speed, timer, hurricane_used, alert, clean_done
  );

  modport slave (
    input  tick_1hz, power_btn, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn,
    output state, speed, timer, hurricane_used, alert, clean_done
  );
endinterface

// File: rtl/hood_mode_scheduler.sv
// Range-hood mode sequencer: power session, one-shot hurricane budget and self-clean.
// Define FUME_POSTRUN_EN to build the level-2 post-run stage after an early hurricane exit.
module hood_mode_scheduler #(
  parameter int HURRICANE_SEC = 60,
  parameter int POSTRUN_SEC   = 60,
  parameter int CLEAN_SEC     = 180,
  parameter int TIMER_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  hood_mode_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_STANDBY   = 3'd1,
    S_EXTRACT   = 3'd2,
    S_HURRICANE = 3'd3,
    S_POSTRUN   = 3'd4,
    S_CLEAN     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE, EV_POWER, EV_MENU, EV_LVL3, EV_LVL2, EV_LVL1, EV_CLEAN, EV_TICK
  } event_e;

  localparam int TMAX = (1 << TIMER_W) - 1;
  // An out-of-range countdown setting keeps the hood parked in OFF instead of running truncated timers.
  localparam bit CFG_OK = (HURRICANE_SEC >= 1) && (HURRICANE_SEC <= TMAX) &&
                          (POSTRUN_SEC >= 1)   && (POSTRUN_SEC <= TMAX)   &&
                          (CLEAN_SEC >= 1)     && (CLEAN_SEC <= TMAX);
  localparam logic [TIMER_W-1:0] HURRICANE_T = TIMER_W'(HURRICANE_SEC);
  localparam logic [TIMER_W-1:0] CLEAN_T     = TIMER_W'(CLEAN_SEC);
`ifdef FUME_POSTRUN_EN
  localparam logic [TIMER_W-1:0] POSTRUN_T   = TIMER_W'(POSTRUN_SEC);
`endif
  localparam logic [TIMER_W-1:0] T_ONE       = TIMER_W'(1);

  state_e             state_q, state_d;
  logic [1:0]         speed_q, speed_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               hu_q, hu_d;
  logic               alert_q, alert_d;
  logic               clean_done_q, clean_done_d;
  event_e             ev;
  logic [1:0]         lvl_speed;

  // Only the highest-priority pulse of the cycle is acted on.
  always_comb begin
    ev = EV_NONE;
    if (bus.power_btn)      ev = EV_POWER;
    else if (bus.menu_btn)  ev = EV_MENU;
    else if (bus.lvl3_btn)  ev = EV_LVL3;
    else if (bus.lvl2_btn)  ev = EV_LVL2;
    else if (bus.lvl1_btn)  ev = EV_LVL1;
    else if (bus.clean_btn) ev = EV_CLEAN;
    else if (bus.tick_1hz)  ev = EV_TICK;
  end

  assign lvl_speed = (ev == EV_LVL1) ? 2'd1 : 2'd2;

  always_comb begin
    state_d      = state_q;
    speed_d      = speed_q;
    timer_d      = timer_q;
    hu_d         = hu_q;
    alert_d      = 1'b0;
    clean_done_d = 1'b0;
    if (state_q != S_OFF && ev == EV_POWER) begin
      state_d = S_OFF;
      speed_d = 2'd0;
      timer_d = '0;
      hu_d    = 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (ev == EV_POWER && CFG_OK) state_d = S_STANDBY;
        end
        S_STANDBY, S_EXTRACT: begin
          case (ev)
            EV_LVL1, EV_LVL2: begin
              state_d = S_EXTRACT;
              speed_d = lvl_speed;
            end
            EV_LVL3: if (!hu_q) begin
              state_d = S_HURRICANE;
              speed_d = 2'd3;
              timer_d = HURRICANE_T;
              hu_d    = 1'b1;
            end
            EV_MENU: if (state_q == S_EXTRACT) begin
              state_d = S_STANDBY;
              speed_d = 2'd0;
            end
            EV_CLEAN: if (state_q == S_STANDBY) begin
              state_d = S_CLEAN;
              speed_d = 2'd1;
              timer_d = CLEAN_T;
            end
            default: ;
          endcase
        end
        S_HURRICANE: begin
          case (ev)
            EV_LVL1, EV_LVL2: begin
              state_d = S_EXTRACT;
              speed_d = lvl_speed;
              timer_d = '0;
            end
            EV_MENU: begin
`ifdef FUME_POSTRUN_EN
              state_d = S_POSTRUN;
              speed_d = 2'd2;
              timer_d = POSTRUN_T;
`else
              state_d = S_STANDBY;
              speed_d = 2'd0;
              timer_d = '0;
`endif
            end
            EV_TICK: begin
              if (timer_q > T_ONE) timer_d = timer_q - T_ONE;
              else if (timer_q == T_ONE) begin
                timer_d = '0;
                alert_d = 1'b1;
                state_d = S_EXTRACT;
                speed_d = 2'd2;
              end
            end
            default: ;
          endcase
        end
`ifdef FUME_POSTRUN_EN
        S_POSTRUN: begin
          case (ev)
            EV_LVL1, EV_LVL2: begin
              state_d = S_EXTRACT;
              speed_d = lvl_speed;
              timer_d = '0;
            end
            EV_MENU: begin
              state_d = S_STANDBY;
              speed_d = 2'd0;
              timer_d = '0;
            end
            EV_TICK: begin
              if (timer_q > T_ONE) timer_d = timer_q - T_ONE;
              else if (timer_q == T_ONE) begin
                timer_d = '0;
                alert_d = 1'b1;
                state_d = S_STANDBY;
                speed_d = 2'd0;
              end
            end
            default: ;
          endcase
        end
`endif
        S_CLEAN: begin
          case (ev)
            EV_MENU: begin
              state_d = S_STANDBY;
              speed_d = 2'd0;
              timer_d = '0;
            end
            EV_TICK: begin
              if (timer_q > T_ONE) timer_d = timer_q - T_ONE;
              else if (timer_q == T_ONE) begin
                timer_d      = '0;
                alert_d      = 1'b1;
                clean_done_d = 1'b1;
                state_d      = S_STANDBY;
                speed_d      = 2'd0;
              end
            end
            default: ;
          endcase
        end
        default: begin
          state_d = S_OFF;
          speed_d = 2'd0;
          timer_d = '0;
          hu_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_OFF;
      speed_q      <= 2'd0;
      timer_q      <= '0;
      hu_q         <= 1'b0;
      alert_q      <= 1'b0;
      clean_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      speed_q      <= speed_d;
      timer_q      <= timer_d;
      hu_q         <= hu_d;
      alert_q      <= alert_d;
      clean_done_q <= clean_done_d;
    end
  end

  assign bus.state          = state_q;
  assign bus.speed          = speed_q;
  assign bus.timer          = timer_q;
  assign bus.hurricane_used = hu_q;
  assign bus.alert          = alert_q;
  assign bus.clean_done     = clean_done_q;

endmodule

// File: doc/hood_mode_scheduler.md
Name: hood_mode_scheduler

Overview:
- Top-level mode sequencer for the range-hood controller.
- Takes single-cycle, already-debounced button pulses and a 1 Hz tick.
- Drives fan speed, countdown display and alert to the display and motor blocks.
- Owns the power session, the one-shot hurricane budget, the post-run and the self-clean sequences.

Parameters:
- HURRICANE_SEC, 60, level-3 burst duration in ticks.
- POSTRUN_SEC, 60, level-2 run-on after leaving hurricane early.
- CLEAN_SEC, 180, self-clean duration in ticks.
- TIMER_W, 8, countdown width; every *_SEC value must be ≤ 2^TIMER_W-1 and ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick_1hz  in  1  one-cycle pulse once per second
- power_btn  in  1  pulse; toggles power
- menu_btn  in  1  pulse; return / exit
- lvl1_btn  in  1  pulse; select level 1
- lvl2_btn  in  1  pulse; select level 2
- lvl3_btn  in  1  pulse; request hurricane
- clean_btn  in  1  pulse; start self-clean
- state  out  3  0 OFF, 1 STANDBY, 2 EXTRACT, 3 HURRICANE, 4 POSTRUN, 5 CLEAN
- speed  out  2  0 stopped, 1/2/3 fan level
- timer  out  TIMER_W  seconds remaining; 0 when no countdown is active
- hurricane_used  out  1  hurricane already consumed in this power session
- alert  out  1  one-cycle pulse on any countdown expiry
- clean_done  out  1  one-cycle pulse when CLEAN completes

Behaviour:
- Reset (rst=0, async): state=OFF, speed=0, timer=0, hurricane_used=0, alert=0, clean_done=0.
- All outputs are registered. An event sampled at edge k is visible after edge k.
- Per-cycle priority: power_btn > menu_btn > lvl3 > lvl2 > lvl1 > clean_btn > tick expiry. Only the highest-priority event acts; the rest are dropped that cycle.
- OFF:
  - power_btn → STANDBY.
  - All other inputs are ignored.
  - speed=0, timer=0.
- power_btn in any non-OFF state → OFF. This also clears hurricane_used and cancels any countdown.
- STANDBY (speed 0):
  - lvl1 → EXTRACT at speed 1; lvl2 → EXTRACT at speed 2.
  - lvl3 → HURRICANE if hurricane_used=0, otherwise ignored.
  - clean_btn → CLEAN.
- EXTRACT (speed 1 or 2, timer 0):
  - lvl1/lvl2 change speed and state is kept.
  - lvl3 → HURRICANE if unused, otherwise ignored (speed unchanged).
  - menu → STANDBY.
  - clean_btn is ignored.
- HURRICANE:
  - On entry: speed=3, timer=HURRICANE_SEC, hurricane_used←1 in the same cycle.
  - lvl1/lvl2 → EXTRACT at that speed; timer←0.
  - menu → POSTRUN.
  - lvl3 and clean are ignored.
- POSTRUN:
  - On entry: speed=2, timer=POSTRUN_SEC.
  - lvl1/lvl2 → EXTRACT.
  - menu → STANDBY immediately.
  - lvl3 is ignored, since hurricane_used is already 1.
- CLEAN:
  - On entry: speed=1, timer=CLEAN_SEC.
  - menu aborts to STANDBY; clean_done stays 0.
  - All level buttons are ignored.
- Countdown rules:
  - In countdown states, a tick with timer>1 decrements timer.
  - A tick with timer==1 is expiry: timer←0, alert=1 for one cycle.
  - HURRICANE expiry → EXTRACT at speed 2.
  - POSTRUN expiry → STANDBY.
  - CLEAN expiry → STANDBY, with clean_done=1 in the same cycle.
  - The total countdown is exactly N ticks after entry. A tick in the entry cycle is not counted.
- A button and a tick in the same cycle: the button wins and the tick is discarded.
- The timer never wraps below 0. Ticks in non-countdown states have no effect.
- Reset mid-countdown aborts the countdown with no alert.
- Unused state encodings 6 and 7 recover to OFF on the next edge.

Optional Feature:
- Macro: FUME_POSTRUN_EN.
- Defined: POSTRUN behaves as described above.
- Undefined:
  - POSTRUN is not implemented.
  - menu in HURRICANE goes directly to STANDBY (speed 0, timer 0, no alert).
  - POSTRUN_SEC is unused and state encoding 4 is never produced.

Test Plan:
- Reset, power_btn, lvl2 → state=2, speed=2. Then menu → state=1, speed=0.
- From STANDBY, lvl3, then 60 ticks → timer 60→1, then alert pulse on tick 60, state=2, speed=2, hurricane_used=1. A second lvl3 is ignored and speed stays 2.
- HURRICANE, 10 ticks, menu → POSTRUN with timer=60, speed=2. After 60 ticks → STANDBY with alert. With FUME_POSTRUN_EN undefined → STANDBY immediately.
- STANDBY, clean_btn, 180 ticks → clean_done and alert on the final tick, state=1. Repeat with menu after 5 ticks → STANDBY, no clean_done.
- power_btn and lvl3 in the same cycle during EXTRACT → OFF, hurricane_used=0. Then power_btn, lvl3 → HURRICANE is allowed again.
- Assert rst low during HURRICANE with timer=30 → all outputs return to reset values immediately, with no alert.
